mem_responder: RTL and testbench

- Memory-side responder for the CPU's memory strobes.
- Accepts Read/Write requests issued by the control unit, with the address taken from MAR and write data from MDR.
- Performs the access on an internal word-addressed RAM after a configurable number of wait states.
- Returns read data to the MDR input mux (Mdatain) and pulses Done so the sequencer can advance.

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU-to-memory strobe bundle: request strobes and operands from the control unit,
// read data and completion status back from the responder.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Read;
    logic                  Write;
    logic [31:0]           MAR;
    logic [DATA_WIDTH-1:0] MDRdata;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  Busy;
    logic                  Done;
    logic                  AddrErr;

    modport master (
        output Read, Write, MAR, MDRdata,
        input  Mdatain, Busy, Done, AddrErr
    );

    modport slave (
        input  Read, Write, MAR, MDRdata,
        output Mdatain, Busy, Done, AddrErr
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write request, waits WAIT_STATES cycles,
// accesses an internal word RAM and pulses Done; re-arms only after strobes drop.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for exactly one strobe; both strobes -> error pulse
// S_WAIT   | request latched, counting down wait states
// S_ACCESS | RAM access happens on the edge leaving this state
// S_HOLD   | completed; waits for Read=Write=0 before re-arming
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  op_wr_q;
    logic                  oor_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mdatain_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  addr_err_q;
    logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];

    logic mar_oor;
    logic ram_we;

    assign mar_oor = |bus.MAR[31:ADDR_WIDTH];
    // Reset at the access edge must kill the write, so the enable is gated by it.
    assign ram_we  = !Reset && (state_q == S_ACCESS) && op_wr_q && !oor_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            oor_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            mdatain_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.Read && bus.Write) begin
                        done_q     <= 1'b1;
                        addr_err_q <= 1'b1;
                        state_q    <= S_HOLD;
                    end else if (bus.Read || bus.Write) begin
                        op_wr_q <= bus.Write;
                        idx_q   <= bus.MAR[ADDR_WIDTH-1:0];
                        oor_q   <= mar_oor;
                        wdata_q <= bus.MDRdata;
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    addr_err_q <= oor_q;
                    if (!op_wr_q) begin
                        mdatain_q <= oor_q ? '0 : ram_q[idx_q];
                    end
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!bus.Read && !bus.Write) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            ram_q[idx_q] <= wdata_q;
        end
    end

    assign bus.Mdatain = mdatain_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.AddrErr = addr_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized requests, all
// checked each cycle against a transaction-level model of the responder.
module tb_mem_responder;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WS = 2;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    mem_responder_if #(.DATA_WIDTH(DW)) bus ();

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    int done_cnt    = 0;
    bit chk_en      = 1'b0;

    // Model: word memory plus the expected output levels for the current cycle.
    logic [DW-1:0] mem [2**AW];
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_err  = 1'b0;
    logic [DW-1:0] exp_mdat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("busy",    32'(bus.Busy),    32'(exp_busy));
            check("done",    32'(bus.Done),    32'(exp_done));
            check("addrerr", 32'(bus.AddrErr), 32'(exp_err));
            check("mdatain", bus.Mdatain,      exp_mdat);
            if (bus.Busy) busy_cnt++;
            if (bus.Done) done_cnt++;
        end
    end

    // One request from strobe assertion to return-to-idle. Returns just after the
    // edge at which the responder is back in IDLE.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [DW-1:0] data, input int hold, input bit scramble);
        logic          oor;
        logic [AW-1:0] idx;
        oor = (addr[31:AW] != '0);
        idx = addr[AW-1:0];
        @(negedge Clock);
        bus.Read    = rd;
        bus.Write   = wr;
        bus.MAR     = addr;
        bus.MDRdata = data;
        @(posedge Clock);
        if (rd && wr) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
        end else begin
            exp_busy = 1'b1;
            if (scramble) begin
                @(negedge Clock);
                bus.MAR     = addr + 32'd1;
                bus.MDRdata = '0;
            end
            repeat (WS) @(posedge Clock);
            @(posedge Clock);
            exp_busy = 1'b0;
            exp_done = 1'b1;
            exp_err  = oor;
            if (rd) exp_mdat = oor ? '0 : mem[idx];
            if (wr && !oor) mem[idx] = data;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge Clock);
            exp_done = 1'b0;
            exp_err  = 1'b0;
        end
        @(negedge Clock);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        @(posedge Clock);
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic        rd, wr;
        int          r;

        Reset       = 1'b1;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.MAR     = '0;
        bus.MDRdata = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_busy",    32'(bus.Busy),    32'd0);
        check("rst_done",    32'(bus.Done),    32'd0);
        check("rst_addrerr", 32'(bus.AddrErr), 32'd0);
        check("rst_mdatain", bus.Mdatain,      32'd0);
        @(negedge Clock);
        Reset  = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 64; i++) begin
            if (i == 16)      run_op(1'b0, 1'b1, 32'(i), 32'h1234_5678, 0, 1'b0);
            else if (i == 48) run_op(1'b0, 1'b1, 32'(i), 32'hCAFE_0030, 0, 1'b0);
            else              run_op(1'b0, 1'b1, 32'(i), 32'hA000_0000 | 32'(i), 0, 1'b0);
        end

        // Write then read 0x55: three Busy cycles each, data returned.
        busy_cnt = 0;
        run_op(1'b0, 1'b1, 32'h55, 32'hDEAD_BEEF, 0, 1'b0);
        #1 check("wr_busy_cycles", 32'(busy_cnt), 32'd3);
        busy_cnt = 0;
        run_op(1'b1, 1'b0, 32'h55, 32'h0, 0, 1'b0);
        #1 check("rd_busy_cycles", 32'(busy_cnt), 32'd3);
        check("rd_55", bus.Mdatain, 32'hDEAD_BEEF);

        // Read held across many cycles produces one access only.
        done_cnt = 0;
        run_op(1'b1, 1'b0, 32'h10, 32'h0, 8, 1'b0);
        #1 check("held_done_pulses", 32'(done_cnt), 32'd1);
        check("held_mdatain", bus.Mdatain, 32'h1234_5678);

        // Operands change one cycle after accept; the latched ones win.
        run_op(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 0, 1'b1);
        run_op(1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        #1 check("latch_20", bus.Mdatain, 32'hA5A5_A5A5);
        run_op(1'b1, 1'b0, 32'h21, 32'h0, 0, 1'b0);
        #1 check("latch_21", bus.Mdatain, 32'hA000_0021);

        // Out-of-range read and write.
        run_op(1'b1, 1'b0, 32'h200, 32'h0, 0, 1'b0);
        #1 check("oor_rd_mdatain", bus.Mdatain, 32'h0);
        run_op(1'b0, 1'b1, 32'h200, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(1'b1, 1'b0, 32'h000, 32'h0, 0, 1'b0);
        #1 check("oor_wr_ram0", bus.Mdatain, 32'hA000_0000);

        // Both strobes: error pulse, no RAM change, Mdatain untouched.
        run_op(1'b1, 1'b0, 32'h55, 32'h0, 0, 1'b0);
        run_op(1'b1, 1'b1, 32'h55, 32'h0, 1, 1'b0);
        #1 check("both_mdatain", bus.Mdatain, 32'hDEAD_BEEF);
        run_op(1'b1, 1'b0, 32'h55, 32'h0, 0, 1'b0);
        #1 check("both_ram55", bus.Mdatain, 32'hDEAD_BEEF);

        // Reset sampled at the access edge of a write to 0x30.
        @(negedge Clock);
        bus.Write   = 1'b1;
        bus.MAR     = 32'h30;
        bus.MDRdata = 32'h0BAD_F00D;
        @(posedge Clock);
        exp_busy = 1'b1;
        repeat (WS) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_mdat = '0;
        @(negedge Clock);
        Reset     = 1'b0;
        bus.Write = 1'b0;
        @(posedge Clock);
        #1 check("rst_mid_busy", 32'(bus.Busy), 32'd0);
        check("rst_mid_mdatain", bus.Mdatain, 32'h0);
        run_op(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
        #1 check("rst_mid_ram30", bus.Mdatain, 32'hCAFE_0030);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 19);
            rd = (r < 9) || (r >= 18);
            wr = (r >= 9);
            if ($urandom_range(0, 9) == 0) begin
                addr = $urandom;
                if (addr[31:AW] == '0) addr[31] = 1'b1;
            end else begin
                addr = 32'($urandom_range(0, 63));
            end
            run_op(rd, wr, addr, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge Clock);
        end

        @(negedge Clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
